// File: rtl/stage_sequencer.sv
// Multi-cycle IFH/ID/EX/MEM/WB sequencer with memory handshakes and halt/fault.
// Optional retired-instruction counter: define STAGE_SEQ_PERF_CNT_EN.
module stage_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned TO_W        = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [5:0]  instr_opcode,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        dmem_req,
  input  logic        dmem_ack,
  output logic [2:0]  stage,
  output logic [5:0]  opcode_q,
  output logic        decode_en,
  output logic        exec_en,
  output logic        wb_en,
  output logic        write_pc,
  output logic        halted,
  output logic        fault,
  output logic [31:0] instr_retired
);

  typedef enum logic [2:0] {
    S_IFH  = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5,
    S_IDLE = 3'd6
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_HALT  = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SUBI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [TO_W-1:0] TO_LIM = TO_W'(MEM_TIMEOUT);
  localparam logic [TO_W-1:0] TO_ONE = TO_W'(1);

  state_e          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [5:0]      opc_d;
  logic            halted_d, fault_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      opcode_q <= '0;
      halted   <= 1'b0;
      fault    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opcode_q <= opc_d;
      halted   <= halted_d;
      fault    <= fault_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    opc_d     = opcode_q;
    halted_d  = halted;
    fault_d   = fault;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    decode_en = 1'b0;
    exec_en   = 1'b0;
    wb_en     = 1'b0;
    write_pc  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_IFH;
      end
      S_IFH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          opc_d   = instr_opcode;
          state_d = S_ID;
        end
      end
      S_ID: begin
        decode_en = 1'b1;
        state_d   = (opcode_q == OP_HALT) ? S_HALT : S_EX;
      end
      S_EX: begin
        exec_en = 1'b1;
        case (opcode_q)
          OP_LW, OP_SW: state_d = S_MEM;
          OP_RTYPE, OP_ADDI, OP_ANDI,
          OP_ORI, OP_SUBI: state_d = S_WB;
          default: begin
            write_pc = 1'b1;
            state_d  = S_IFH;
          end
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        // A late ack in the limit cycle still completes the access.
        if (dmem_ack) begin
          cnt_d = '0;
          if (opcode_q == OP_SW) begin
            write_pc = 1'b1;
            state_d  = S_IFH;
          end else begin
            state_d = S_WB;
          end
        end else if (cnt_q + TO_ONE == TO_LIM) begin
          cnt_d   = '0;
          fault_d = 1'b1;
          state_d = S_HALT;
        end else begin
          cnt_d = cnt_q + TO_ONE;
        end
      end
      S_WB: begin
        wb_en    = 1'b1;
        write_pc = 1'b1;
        state_d  = S_IFH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (state_d == S_HALT) halted_d = 1'b1;
  end

  assign stage = state_q;

`ifdef STAGE_SEQ_PERF_CNT_EN
  logic [31:0] ret_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ret_q <= '0;
    end else if (write_pc && state_q != S_HALT) begin
      ret_q <= ret_q + 32'd1;
    end
  end

  assign instr_retired = ret_q;
`else
  assign instr_retired = '0;
`endif

endmodule

// File: doc/stage_sequencer.md
Name: stage_sequencer

Overview:
- Multi-cycle stage sequencer for the core. Steps each instruction through IFH, ID, EX, MEM and WB, and skips the stages an opcode does not need.
- Drives one-cycle stage enables to the datapath and the per-stage decode in the control unit.
- Owns the instruction and data memory request/acknowledge handshakes, the write_pc strobe, and halt/fault detection.

Parameters:
- MEM_TIMEOUT, 15, max cycles dmem_req may stay high without dmem_ack before a fault (1..255).
- TO_W, 8, width of the timeout counter; must hold MEM_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  leave IDLE and begin fetching; ignored in every other state
- instr_opcode  in  6  opcode field of fetched word; valid while imem_ack=1
- imem_req  out  1  instruction fetch request
- imem_ack  in  1  fetch complete
- dmem_req  out  1  data memory access request
- dmem_ack  in  1  data access complete
- stage  out  3  current state code
- opcode_q  out  6  latched opcode of the current instruction
- decode_en  out  1  high for the single ID cycle
- exec_en  out  1  high for the single EX cycle
- wb_en  out  1  high for the single WB cycle
- write_pc  out  1  one-cycle strobe in the final cycle of each retired instruction
- halted  out  1  sticky; set on entering HALT
- fault  out  1  sticky; set on memory timeout
- instr_retired  out  32  retired instruction count (see optional feature)

Behaviour:
- State codes: IFH=0, ID=1, EX=2, MEM=3, WB=4, HALT=5, IDLE=6. State is registered.
- All outputs are combinational decodes of state, except opcode_q, halted, fault and instr_retired, which are registered.
- Reset (rst_n=0, any cycle, including mid-handshake): state=IDLE; opcode_q=0; halted=0; fault=0; timeout counter=0; instr_retired=0. All enables and requests are 0 immediately.
- IDLE: start=1 -> IFH on the next edge.
- IFH:
  - imem_req=1, held while waiting.
  - imem_ack is sampled every IFH cycle, including the first, so zero-wait fetch takes 1 cycle.
  - On ack: opcode_q<=instr_opcode, -> ID.
- ID: decode_en=1. opcode_q==6'b000010 (halt) -> HALT; otherwise -> EX.
- EX: exec_en=1. Next state by opcode_q:
  - lw 6'b100011 or sw 6'b101011 -> MEM.
  - r_type 6'b000000, addi 6'b001000, andi 6'b001100, ori 6'b001101, subi 6'b001110 -> WB.
  - Everything else (jr, jpc, brfl, call, ret, nop, unknown): write_pc=1 this cycle, -> IFH.
- MEM:
  - dmem_req=1; the timeout counter increments each cycle without ack.
  - On dmem_ack: counter<=0. lw -> WB. sw -> IFH with write_pc=1 this cycle.
  - Counter reaches MEM_TIMEOUT with no ack: fault<=1, -> HALT. dmem_req drops next cycle.
  - Ack arriving in the same cycle the counter reaches MEM_TIMEOUT: the ack wins, no fault.
- WB: wb_en=1, write_pc=1, -> IFH.
- HALT: halted=1; all requests and enables are 0; start is ignored. The only exit is reset.
- Latencies with zero-wait memory:
  - ALU op: 4 cycles (IFH, ID, EX, WB).
  - lw: 5 cycles.
  - sw: 4 cycles.
  - Branch/other: 3 cycles.
- At most one enable or request is high in any cycle. write_pc is never high outside EX, MEM or WB.

Optional Feature:
- Macro: STAGE_SEQ_PERF_CNT_EN.
- Defined: instr_retired increments by 1 on each cycle with write_pc=1. It wraps from 32'hFFFFFFFF to 0 and freezes in HALT.
- Undefined: instr_retired is tied to 0 and no counter is built.

Test Plan:
- Reset, start=1, imem_ack tied 1, opcode 6'b000000 -> stages 0,1,2,4; write_pc=1 only in the WB cycle; 4 cycles per instruction.
- lw with dmem_ack delayed 3 cycles -> dmem_req high 4 cycles, then WB; write_pc once; counter back to 0.
- sw, dmem_ack immediate -> MEM lasts 1 cycle with write_pc=1; wb_en never asserted.
- jpc 6'b001001 then halt 6'b000010 -> jpc retires from EX with write_pc; halt goes ID->HALT, halted=1; start=1 afterwards changes nothing.
- lw with dmem_ack held 0 and MEM_TIMEOUT=15 -> fault=1 and HALT after 15 MEM cycles; repeat with ack on cycle 15 -> no fault.
- rst_n pulsed low mid-MEM -> imem_req/dmem_req drop with no clock edge; state=IDLE. With STAGE_SEQ_PERF_CNT_EN, after 10 retired instructions instr_retired=10, and reset clears it to 0.
